// File: rtl/pwm_pkg.sv
// Shared types, parameter limits and helpers for the multi-channel PWM.
// Center-aligned operation is built only when PWM_CENTER_ALIGN_EN is defined.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        PWM_DIR_UP   = 1'b0,
        PWM_DIR_DOWN = 1'b1
    } pwm_dir_e;

    localparam int unsigned PWM_MIN_CHANNELS = 1;
    localparam int unsigned PWM_MAX_CHANNELS = 16;
    localparam int unsigned PWM_MIN_WIDTH    = 2;
    localparam int unsigned PWM_MAX_WIDTH    = 16;
    localparam int unsigned PWM_VEC_W        = PWM_MAX_CHANNELS * PWM_MAX_WIDTH;

    function automatic bit pwm_params_ok(input int unsigned channels, input int unsigned width);
        return (channels >= PWM_MIN_CHANNELS) && (channels <= PWM_MAX_CHANNELS) &&
               (width >= PWM_MIN_WIDTH) && (width <= PWM_MAX_WIDTH);
    endfunction

    // Extracts channel ch of a packed per-channel vector, zero-extended to the widest slice.
    function automatic logic [PWM_MAX_WIDTH-1:0] pwm_slice(
        input logic [PWM_VEC_W-1:0] vec,
        input int unsigned          ch,
        input int unsigned          width
    );
        logic [PWM_MAX_WIDTH-1:0] mask;
        mask = PWM_MAX_WIDTH'((32'd1 << width) - 32'd1);
        return PWM_MAX_WIDTH'(vec >> (ch * width)) & mask;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM counter: wrap/up-down sequencing, boundary detect and period_end.
// Direction register and center-aligned sequencing exist only with PWM_CENTER_ALIGN_EN.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] period,
`ifdef PWM_CENTER_ALIGN_EN
    input  pwm_mode_e        mode,
`endif
    output logic [WIDTH-1:0] count,
    output logic             boundary,
    output logic             period_end
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             period_end_q, period_end_d;
`ifdef PWM_CENTER_ALIGN_EN
    pwm_dir_e         dir_q, dir_d;
`endif

    always_comb begin
        count_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d   = PWM_DIR_UP;
        if (enable) begin
            if (mode == PWM_CENTER) begin
                // Turn around at P, count down and hand back to "up" on the way into 0.
                if (period == '0) begin
                    count_d = '0;
                end else if (dir_q == PWM_DIR_UP && count_q < period) begin
                    count_d = count_q + WIDTH'(1);
                end else begin
                    count_d = (dir_q == PWM_DIR_UP) ? period - WIDTH'(1) : count_q - WIDTH'(1);
                    dir_d   = (count_d == '0) ? PWM_DIR_UP : PWM_DIR_DOWN;
                end
            end else begin
                count_d = (count_q >= period) ? '0 : count_q + WIDTH'(1);
            end
        end
`else
        if (enable) begin
            count_d = (count_q >= period) ? '0 : count_q + WIDTH'(1);
        end
`endif
        boundary     = enable && (count_d == '0);
        period_end_d = enable && (count_q == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            period_end_q <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q        <= PWM_DIR_UP;
`endif
        end else begin
            count_q      <= count_d;
            period_end_q <= period_end_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q        <= dir_d;
`endif
        end
    end

    assign count      = count_q;
    assign period_end = period_end_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with double-buffered period/duty applied at period boundaries.
// Define PWM_CENTER_ALIGN_EN to add the center_mode port and center-aligned counting.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      load,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic                      center_mode,
`endif
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_end,
    output logic                      load_pending
);

    if (!pwm_params_ok(CHANNELS, WIDTH)) begin : g_bad_params
        $error("pwm_multi_channel: CHANNELS must be 1..16 and WIDTH 2..16");
    end

    logic [WIDTH-1:0] count;
    logic             boundary;
    logic [WIDTH-1:0] period_act_q, period_act_d;
    logic [WIDTH-1:0] period_pend_q, period_pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             apply, take_load, take_pend, capture;
`ifdef PWM_CENTER_ALIGN_EN
    pwm_mode_e        mode_act_q, mode_act_d;
    pwm_mode_e        mode_pend_q, mode_pend_d;
`endif

    // Disabled cycles count as boundaries so pending values land while idle;
    // a load in an applying cycle bypasses the pending registers entirely.
    assign apply     = !enable || boundary;
    assign take_load = apply && load;
    assign take_pend = apply && !load && pend_valid_q;
    assign capture   = load && !apply;

    always_comb begin
        pend_valid_d  = capture ? 1'b1 : (apply ? 1'b0 : pend_valid_q);
        period_pend_d = capture ? period : period_pend_q;
        period_act_d  = take_load ? period : (take_pend ? period_pend_q : period_act_q);
`ifdef PWM_CENTER_ALIGN_EN
        mode_pend_d   = capture ? pwm_mode_e'(center_mode) : mode_pend_q;
        mode_act_d    = take_load ? pwm_mode_e'(center_mode) : (take_pend ? mode_pend_q : mode_act_q);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_act_q  <= '1;
            period_pend_q <= '0;
            pend_valid_q  <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            mode_act_q    <= PWM_EDGE;
            mode_pend_q   <= PWM_EDGE;
`endif
        end else begin
            period_act_q  <= period_act_d;
            period_pend_q <= period_pend_d;
            pend_valid_q  <= pend_valid_d;
`ifdef PWM_CENTER_ALIGN_EN
            mode_act_q    <= mode_act_d;
            mode_pend_q   <= mode_pend_d;
`endif
        end
    end

    pwm_timebase #(.WIDTH(WIDTH)) u_timebase (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .period     (period_act_q),
`ifdef PWM_CENTER_ALIGN_EN
        .mode       (mode_act_q),
`endif
        .count      (count),
        .boundary   (boundary),
        .period_end (period_end)
    );

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] duty_req;
        logic [WIDTH-1:0] duty_pend_q, duty_pend_d;
        logic [WIDTH-1:0] duty_act_q, duty_act_d;
        logic             pwm_q, pwm_d;

        assign duty_req = WIDTH'(pwm_slice(PWM_VEC_W'(duty), i, WIDTH));

        always_comb begin
            duty_pend_d = capture ? duty_req : duty_pend_q;
            duty_act_d  = take_load ? duty_req : (take_pend ? duty_pend_q : duty_act_q);
            pwm_d       = enable && (count < duty_act_q);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                duty_pend_q <= '0;
                duty_act_q  <= '0;
                pwm_q       <= 1'b0;
            end else begin
                duty_pend_q <= duty_pend_d;
                duty_act_q  <= duty_act_d;
                pwm_q       <= pwm_d;
            end
        end

        assign pwm_out[i] = pwm_q;
    end

    assign load_pending = pend_valid_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed self-checking bench for pwm_multi_channel (4 channels, 8-bit).
// Center-aligned steps run only when PWM_CENTER_ALIGN_EN is defined.
module tb_pwm_multi_channel;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              load;
    logic [W-1:0]      period;
    logic [CH*W-1:0]   duty;
`ifdef PWM_CENTER_ALIGN_EN
    logic              center_mode;
`endif
    logic [CH-1:0]     pwm_out;
    logic              period_end;
    logic              load_pending;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned pe_cnt, pe_prev, pe_last;
    int unsigned hi [CH];

    always #5 clk = ~clk;

    pwm_multi_channel #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .period       (period),
        .duty         (duty),
        .load         (load),
`ifdef PWM_CENTER_ALIGN_EN
        .center_mode  (center_mode),
`endif
        .pwm_out      (pwm_out),
        .period_end   (period_end),
        .load_pending (load_pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        pe_cnt  = 0;
        pe_prev = 0;
        pe_last = 0;
        for (int i = 0; i < CH; i++) hi[i] = 0;
    endtask

    // One clock; observe registered outputs 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (period_end === 1'b1) begin
            pe_cnt++;
            pe_prev = pe_last;
            pe_last = cyc;
        end
        for (int i = 0; i < CH; i++) if (pwm_out[i] === 1'b1) hi[i]++;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) step();
    endtask

    task automatic set_duty(input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [W-1:0] d3);
        duty = {d3, d2, d1, d0};
    endtask

    task automatic do_load();
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_applied(input string tag);
        int unsigned n;
        n = 0;
        while (load_pending === 1'b1 && n < 600) begin
            step();
            n++;
        end
        check(tag, 32'(load_pending), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        period = '0;
        duty   = '0;
`ifdef PWM_CENTER_ALIGN_EN
        center_mode = 1'b0;
`endif
        clr();
        step();
        step();
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_pe", 32'(period_end), 32'd0);
        check("rst_lp", 32'(load_pending), 32'd0);

        // Reset defaults: period 255, duty 0
        reset  = 1'b0;
        enable = 1'b1;
        clr();
        run(257);
        check("p255_pe_cnt", pe_cnt, 32'd2);
        check("p255_pe_gap", pe_last - pe_prev, 32'd256);
        check("p255_hi", hi[0] + hi[1] + hi[2] + hi[3], 32'd0);

        // Maximum duty at P = all-ones
        period = 8'hFF;
        set_duty(8'd255, 8'd255, 8'd0, 8'd0);
        do_load();
        check("max_lp", 32'(load_pending), 32'd1);
        wait_applied("max_apply");
        clr();
        run(256);
        check("max_hi0", hi[0], 32'd255);
        check("max_hi2", hi[2], 32'd0);
        check("max_pe", pe_cnt, 32'd1);

        // P = 0: period_end continuous
        period = 8'd0;
        set_duty(8'd0, 8'd1, 8'd0, 8'd0);
        do_load();
        wait_applied("p0_apply");
        clr();
        run(5);
        check("p0_pe", pe_cnt, 32'd5);
        check("p0_hi1", hi[1], 32'd5);
        check("p0_hi0", hi[0], 32'd0);

`ifdef PWM_CENTER_ALIGN_EN
        // Center mode P=4: counts 0,1,2,3,4,3,2,1
        center_mode = 1'b1;
        period = 8'd4;
        set_duty(8'd0, 8'd2, 8'd5, 8'd1);
        do_load();
        check("ctr_lp", 32'(load_pending), 32'd0);
        clr();
        run(8);
        check("ctr_hi0", hi[0], 32'd0);
        check("ctr_hi1", hi[1], 32'd3);
        check("ctr_hi2", hi[2], 32'd8);
        check("ctr_hi3", hi[3], 32'd1);
        check("ctr_pe", pe_cnt, 32'd1);
        clr();
        run(16);
        check("ctr_pe_gap", pe_last - pe_prev, 32'd8);
        center_mode = 1'b0;
`endif

        // Edge mode P=9, duties 0/3/10/255
        period = 8'd9;
        set_duty(8'd0, 8'd3, 8'd10, 8'd255);
        do_load();
        wait_applied("p9_apply");
        clr();
        run(20);
        check("p9_hi0", hi[0], 32'd0);
        check("p9_hi1", hi[1], 32'd6);
        check("p9_hi2", hi[2], 32'd20);
        check("p9_hi3", hi[3], 32'd20);
        check("p9_pe", pe_cnt, 32'd2);
        check("p9_pe_gap", pe_last - pe_prev, 32'd10);

        // Mid-period load at count 5: duty 3 -> 7
        set_duty(8'd0, 8'd7, 8'd10, 8'd255);
        clr();
        run(5);
        do_load();
        check("mid_lp_set", 32'(load_pending), 32'd1);
        run(3);
        check("mid_lp_hold", 32'(load_pending), 32'd1);
        run(1);
        check("mid_lp_clr", 32'(load_pending), 32'd0);
        check("mid_old_hi1", hi[1], 32'd3);
        clr();
        run(10);
        check("mid_new_hi1", hi[1], 32'd7);
        check("mid_pe", pe_cnt, 32'd1);

        // Load in the boundary cycle (count 9)
        run(9);
        set_duty(8'd0, 8'd5, 8'd10, 8'd255);
        do_load();
        check("bnd_lp", 32'(load_pending), 32'd0);
        clr();
        run(10);
        check("bnd_hi1", hi[1], 32'd5);

        // Two loads in one period: last wins
        set_duty(8'd0, 8'd2, 8'd10, 8'd255);
        do_load();
        step();
        set_duty(8'd0, 8'd6, 8'd10, 8'd255);
        do_load();
        check("two_lp", 32'(load_pending), 32'd1);
        run(7);
        check("two_lp_clr", 32'(load_pending), 32'd0);
        clr();
        run(10);
        check("two_hi1", hi[1], 32'd6);

        // Enable dropped mid-period with a pending load
        run(2);
        set_duty(8'd0, 8'd8, 8'd10, 8'd255);
        do_load();
        check("en_lp", 32'(load_pending), 32'd1);
        enable = 1'b0;
        step();
        check("en_pwm", 32'(pwm_out), 32'd0);
        check("en_pe", 32'(period_end), 32'd0);
        check("en_lp_clr", 32'(load_pending), 32'd0);
        step();
        step();
        check("en_pwm_hold", 32'(pwm_out), 32'd0);
        enable = 1'b1;
        clr();
        step();
        check("en_restart_pe", 32'(period_end), 32'd1);
        check("en_restart_pwm", 32'(pwm_out), 32'h0E);
        run(9);
        check("en_hi1", hi[1], 32'd8);
        check("en_pe_cnt", pe_cnt, 32'd1);

        // Reset mid-period discards pending values
        run(3);
        period = 8'd5;
        set_duty(8'd0, 8'd1, 8'd10, 8'd255);
        do_load();
        check("rst2_lp", 32'(load_pending), 32'd1);
        reset = 1'b1;
        #1;
        check("rst2_pwm", 32'(pwm_out), 32'd0);
        check("rst2_pe", 32'(period_end), 32'd0);
        check("rst2_lp_clr", 32'(load_pending), 32'd0);
        step();
        step();
        reset = 1'b0;
        clr();
        run(20);
        check("rst2_hi", hi[0] + hi[1] + hi[2] + hi[3], 32'd0);
        check("rst2_pe_cnt", pe_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Multi-channel PWM generator with a shared, programmable-period timebase and per-channel duty compare. Duty and period are double-buffered and applied only at a period boundary, so outputs never glitch mid-period. The block sits between the register interface or control logic and the motor/LED/actuator pads, replacing the fixed 8-bit, free-running, single-channel PWM.

## Interface
- CHANNELS, 4, number of independent PWM outputs sharing one timebase (1..16)
- WIDTH, 8, counter, period and duty width in bits (2..16)

- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- enable  input  1  run timebase; low holds counter at 0 and forces outputs low
- period  input  WIDTH  requested terminal count P
- duty  input  CHANNELS*WIDTH  requested duty per channel, channel i at [i*WIDTH +: WIDTH]
- load  input  1  one-cycle strobe: capture period/duty (and center_mode) into pending registers
- center_mode  input  1  requested alignment, 0 = edge, 1 = center (present only with PWM_CENTER_ALIGN_EN)
- pwm_out  output  CHANNELS  registered PWM outputs
- period_end  output  1  one-cycle pulse, aligned with the pwm_out sample for count 0
- load_pending  output  1  high from the cycle after load until pending values are applied

## Operation
- Reset values: counter 0, direction up, active period all-ones, active duty 0, active mode edge, pending empty, pwm_out 0, period_end 0, load_pending 0.
- Edge mode: counter 0,1,…,P then wraps to 0; period = P+1 cycles.
- Center mode: counter 0 up to P, then P-1 down to 1, then 0; period = 2P cycles; P = 0 holds counter at 0 (period 1 cycle).
- Compare: pwm_out[i] = (count < duty_active[i]), unsigned, WIDTH bits. duty 0 → constant low; duty > P → constant high. Edge mode, P = all-ones: maximum high fraction is (2^WIDTH−1)/2^WIDTH.
- Boundary cycle: a cycle in which count_next = 0 and enable is high.
- load: period/duty/center_mode captured into pending; load_pending set. A second load before application overwrites pending (last wins).
- Application: at a boundary cycle, if pending is valid, active ← pending and load_pending clears; the new values govern count 0 onwards. A load asserted in the boundary cycle itself is applied at that same boundary.
- enable low: counter forced to 0, direction up, pwm_out 0, period_end 0; pending values are applied on the next clock edge while disabled. Reasserting enable starts at count 0.
- Reset mid-period: all state returns to reset values immediately; pending values are discarded.

## Timing
- pwm_out and period_end are registered: the value at cycle t+1 reflects the count and active values at cycle t (1-cycle latency).
- period_end pulses once per period. Edge mode, P = 0: it is high continuously while enabled.
- Latency from load to effect: 1 to one full period plus 1 cycle.
- load_pending rises 1 cycle after load and falls 1 cycle after the applying boundary.

## Configuration
- PWM_CENTER_ALIGN_EN defined: center_mode port, up/down counter direction and center-aligned behaviour are present.
- PWM_CENTER_ALIGN_EN not defined: center_mode port is absent; the block runs edge-aligned only, and the direction register and active-mode register are removed.

## Structure
- Shared package pwm_pkg: pwm_mode_e enum (PWM_EDGE, PWM_CENTER), parameter range-check localparams, and a channel-slice helper function.
- Sub-module pwm_timebase: counter, direction, boundary detect and the period_end source. Compare and the pending/active registers stay in pwm_multi_channel, one generate loop per channel.

## Test plan
- Reset, enable=1, no load → period 0xFF, duty 0: pwm_out = 0 throughout; period_end every 256 cycles.
- Edge mode, load P=9 with duties 0/3/10/255 → after boundary: ch0 always low, ch1 high 3 of 10 cycles, ch2 and ch3 always high; period_end every 10 cycles.
- Mid-period load, duty 3→7 at count 5 → current period keeps 3 high cycles, next period has 7; load_pending high until the boundary.
- Load on a boundary cycle, and two loads within one period → the boundary-cycle load applies immediately; for the two loads, only the last value appears.
- Center mode, P=4, duty 2 → count sequence 0,1,2,3,4,3,2,1; pwm_out high for counts 0,1,1 (3 of 8 cycles), symmetric around count 0.
- Reset asserted, and separately enable dropped, mid-period → outputs 0 within 1 cycle; on restart, count resumes at 0 with reset values or applied pending values respectively.
